// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss/refill sequencer: optional dirty-victim writeback, block fetch,
// then a one-cycle block write into the cache, stalling the pipeline throughout.
module dcache_miss_ctrl #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   mem_access_i,
    input  logic                   dcache_hit_i,
    input  logic                   dcache_dirty_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [ADDR_WIDTH-1:0]  addr_wb_i,
    input  logic [BLOCK_WIDTH-1:0] victim_block_i,
    input  logic                   axi_done_i,
    input  logic [BLOCK_WIDTH-1:0] axi_rdata_i,
    output logic                   stall_o,
    output logic                   axi_read_start_o,
    output logic                   axi_write_start_o,
    output logic [ADDR_WIDTH-1:0]  axi_addr_o,
    output logic [BLOCK_WIDTH-1:0] axi_wdata_o,
    output logic                   block_we_o,
    output logic [BLOCK_WIDTH-1:0] data_block_o,
    output logic [CNT_WIDTH-1:0]   miss_cnt_o,
    output logic [CNT_WIDTH-1:0]   wb_cnt_o,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        FILL = 2'd3
    } state_t;

    // Byte-offset bits inside one cache block; cleared to block-align addresses.
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] refill_addr;
    logic                  miss;
    logic                  wb_done;
    logic                  rd_done;

    // AXI handshake: a start pulse issues one block transaction; the matching
    // axi_done_i pulse completes it and counts only from the cycle after the start.
    assign miss    = (state == IDLE) & mem_access_i & ~dcache_hit_i;
    assign wb_done = (state == WB) & axi_done_i & ~axi_write_start_o;
    assign rd_done = (state == RD) & axi_done_i & ~axi_read_start_o;

    assign stall_o     = ~arst_i & ((state != IDLE) | miss);
    assign dbg_state_o = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss) state_next = dcache_dirty_i ? WB : RD;
            WB:      if (wb_done) state_next = RD;
            RD:      if (rd_done) state_next = FILL;
            FILL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state             <= IDLE;
            refill_addr       <= '0;
            axi_read_start_o  <= 1'b0;
            axi_write_start_o <= 1'b0;
            axi_addr_o        <= '0;
            axi_wdata_o       <= '0;
            block_we_o        <= 1'b0;
            data_block_o      <= '0;
            miss_cnt_o        <= '0;
            wb_cnt_o          <= '0;
        end else begin
            state             <= state_next;
            axi_write_start_o <= (state != WB) && (state_next == WB);
            axi_read_start_o  <= (state != RD) && (state_next == RD);
            block_we_o        <= (state_next == FILL);
            case (state)
                IDLE: begin
                    if (miss && dcache_dirty_i) begin
                        axi_addr_o  <= addr_wb_i & ~OFS_MASK;
                        axi_wdata_o <= victim_block_i;
                        refill_addr <= addr_i & ~OFS_MASK;
                    end else if (miss) begin
                        axi_addr_o  <= addr_i & ~OFS_MASK;
                    end
                end
                WB: begin
                    if (wb_done) begin
                        wb_cnt_o   <= wb_cnt_o + CNT_WIDTH'(1);
                        axi_addr_o <= refill_addr;
                    end
                end
                RD: begin
                    if (rd_done) data_block_o <= axi_rdata_i;
                end
                FILL: begin
                    miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: inputs change at the falling edge and
// outputs are checked 1 ns later, with hand-computed per-cycle expectations.
module tb_dcache_miss_ctrl;

    localparam int AW = 64;
    localparam int BW = 512;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          arst;
    logic          mem_access;
    logic          dcache_hit;
    logic          dcache_dirty;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_wb;
    logic [BW-1:0] victim_block;
    logic          axi_done;
    logic [BW-1:0] axi_rdata;
    logic          stall;
    logic          axi_read_start;
    logic          axi_write_start;
    logic [AW-1:0] axi_addr;
    logic [BW-1:0] axi_wdata;
    logic          block_we;
    logic [BW-1:0] data_block;
    logic [CW-1:0] miss_cnt;
    logic [CW-1:0] wb_cnt;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] blk_a = {16{32'hCAFE_0001}};
    logic [BW-1:0] blk_b = {16{32'h1234_ABCD}};
    logic [BW-1:0] blk_v = {16{32'hDEAD_BEEF}};

    dcache_miss_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .arst_i(arst), .mem_access_i(mem_access), .dcache_hit_i(dcache_hit),
        .dcache_dirty_i(dcache_dirty), .addr_i(addr), .addr_wb_i(addr_wb),
        .victim_block_i(victim_block), .axi_done_i(axi_done), .axi_rdata_i(axi_rdata),
        .stall_o(stall), .axi_read_start_o(axi_read_start), .axi_write_start_o(axi_write_start),
        .axi_addr_o(axi_addr), .axi_wdata_o(axi_wdata), .block_we_o(block_we),
        .data_block_o(data_block), .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1; mem_access = 1'b0; dcache_hit = 1'b0; axi_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            arst = 1'b1; mem_access = 1'b1; dcache_hit = 1'b0;
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall c%0d got %b exp 0", c, stall); end
            checks++; if ({axi_read_start, axi_write_start, block_we} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {axi_read_start, axi_write_start, block_we}); end
            checks++; if (axi_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", axi_addr); end
            checks++; if (axi_wdata !== '0 || data_block !== '0) begin errors++; $display("FAIL reset_data got %h / %h exp 0", axi_wdata, data_block); end
            checks++; if (miss_cnt !== '0 || wb_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", miss_cnt, wb_cnt); end
            checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        end
        @(negedge clk);
        arst = 1'b0; mem_access = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL reset_release got stall %b state %0d exp 0 0", stall, dbg_state); end
    endtask

    task automatic test_clean_miss();
        int stall_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mem_access = 1'b1; dcache_hit = (c >= 8); dcache_dirty = 1'b0;
            addr = 64'h8000_1234; axi_done = (c == 6); axi_rdata = blk_a;
            #1;
            if (stall) stall_cycles++;
            checks++; if (stall !== (c < 8)) begin errors++; $display("FAIL clean_stall c%0d got %b exp %b", c, stall, c < 8); end
            checks++; if (axi_read_start !== (c == 1)) begin errors++; $display("FAIL clean_rd_start c%0d got %b exp %b", c, axi_read_start, c == 1); end
            checks++; if (axi_write_start !== 1'b0) begin errors++; $display("FAIL clean_wr_start c%0d got %b exp 0", c, axi_write_start); end
            checks++; if (block_we !== (c == 7)) begin errors++; $display("FAIL clean_we c%0d got %b exp %b", c, block_we, c == 7); end
            if (c == 1) begin
                checks++; if (axi_addr !== 64'h8000_1200) begin errors++; $display("FAIL clean_addr got %h exp 80001200", axi_addr); end
            end
            if (c == 7) begin
                checks++; if (data_block !== blk_a) begin errors++; $display("FAIL clean_data got %h exp %h", data_block, blk_a); end
            end
        end
        axi_done = 1'b0; mem_access = 1'b0;
        checks++; if (stall_cycles != 8) begin errors++; $display("FAIL clean_stall_len got %0d exp 8", stall_cycles); end
        checks++; if (miss_cnt !== 32'd1 || wb_cnt !== 32'd0) begin errors++; $display("FAIL clean_cnt got %0d/%0d exp 1/0", miss_cnt, wb_cnt); end
    endtask

    task automatic test_dirty_miss();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_access = 1'b1; dcache_hit = (c >= 10); dcache_dirty = 1'b1;
            addr = 64'h1040; addr_wb = 64'h2040; victim_block = blk_v;
            axi_done = (c == 4 || c == 8); axi_rdata = blk_b;
            #1;
            checks++; if (stall !== (c < 10)) begin errors++; $display("FAIL dirty_stall c%0d got %b exp %b", c, stall, c < 10); end
            checks++; if (axi_write_start !== (c == 1)) begin errors++; $display("FAIL dirty_wr_start c%0d got %b exp %b", c, axi_write_start, c == 1); end
            checks++; if (axi_read_start !== (c == 5)) begin errors++; $display("FAIL dirty_rd_start c%0d got %b exp %b", c, axi_read_start, c == 5); end
            checks++; if (block_we !== (c == 9)) begin errors++; $display("FAIL dirty_we c%0d got %b exp %b", c, block_we, c == 9); end
            if (c == 1) begin
                checks++; if (axi_addr !== 64'h2040) begin errors++; $display("FAIL dirty_wb_addr got %h exp 2040", axi_addr); end
                checks++; if (axi_wdata !== blk_v) begin errors++; $display("FAIL dirty_wdata got %h exp %h", axi_wdata, blk_v); end
            end
            if (c == 2) begin
                checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL dirty_state_wb got %0d exp 1", dbg_state); end
            end
            if (c == 5) begin
                checks++; if (axi_addr !== 64'h1040) begin errors++; $display("FAIL dirty_rd_addr got %h exp 1040", axi_addr); end
            end
            if (c == 9) begin
                checks++; if (data_block !== blk_b) begin errors++; $display("FAIL dirty_data got %h exp %h", data_block, blk_b); end
            end
        end
        axi_done = 1'b0; mem_access = 1'b0;
        checks++; if (miss_cnt !== 32'd1 || wb_cnt !== 32'd1) begin errors++; $display("FAIL dirty_cnt got %0d/%0d exp 1/1", miss_cnt, wb_cnt); end
    endtask

    task automatic test_spurious_done();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mem_access = (c >= 2); dcache_hit = (c >= 8); dcache_dirty = 1'b0;
            addr = 64'h3000; axi_done = (c == 0 || c == 3 || c == 6); axi_rdata = blk_a;
            #1;
            checks++; if (stall !== (c >= 2 && c < 8)) begin errors++; $display("FAIL spur_stall c%0d got %b exp %b", c, stall, c >= 2 && c < 8); end
            checks++; if (axi_read_start !== (c == 3)) begin errors++; $display("FAIL spur_rd_start c%0d got %b exp %b", c, axi_read_start, c == 3); end
            checks++; if (block_we !== (c == 7)) begin errors++; $display("FAIL spur_we c%0d got %b exp %b", c, block_we, c == 7); end
            if (c == 1) begin
                checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL spur_idle_state got %0d exp 0", dbg_state); end
                checks++; if (miss_cnt !== 32'd1 || wb_cnt !== 32'd1) begin errors++; $display("FAIL spur_idle_cnt got %0d/%0d exp 1/1", miss_cnt, wb_cnt); end
            end
            if (c == 4 || c == 5) begin
                checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL spur_rd_state c%0d got %0d exp 2", c, dbg_state); end
            end
        end
        axi_done = 1'b0; mem_access = 1'b0;
        checks++; if (miss_cnt !== 32'd2 || wb_cnt !== 32'd1) begin errors++; $display("FAIL spur_cnt got %0d/%0d exp 2/1", miss_cnt, wb_cnt); end
    endtask

    task automatic test_reset_mid_rd();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            arst = (c == 3); mem_access = (c < 3); dcache_hit = 1'b0; dcache_dirty = 1'b0;
            addr = 64'h4000; axi_done = (c == 4 || c == 6); axi_rdata = blk_b;
            #1;
            checks++; if (stall !== (c < 3)) begin errors++; $display("FAIL midrd_stall c%0d got %b exp %b", c, stall, c < 3); end
            checks++; if (axi_read_start !== (c == 1)) begin errors++; $display("FAIL midrd_rd_start c%0d got %b exp %b", c, axi_read_start, c == 1); end
            checks++; if (block_we !== 1'b0) begin errors++; $display("FAIL midrd_we c%0d got %b exp 0", c, block_we); end
            if (c >= 4) begin
                checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midrd_state c%0d got %0d exp 0", c, dbg_state); end
                checks++; if (axi_addr !== '0 || data_block !== '0) begin errors++; $display("FAIL midrd_regs c%0d got %h / %h exp 0", c, axi_addr, data_block); end
                checks++; if (miss_cnt !== '0 || wb_cnt !== '0) begin errors++; $display("FAIL midrd_cnt c%0d got %0d/%0d exp 0/0", c, miss_cnt, wb_cnt); end
            end
        end
        axi_done = 1'b0;
    endtask

    task automatic test_hit_no_access();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            mem_access = (c < 4); dcache_hit = (c < 4); dcache_dirty = 1'b1;
            addr = 64'h7777_0000; axi_done = 1'b0;
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hit_stall c%0d got %b exp 0", c, stall); end
            checks++; if ({axi_read_start, axi_write_start, block_we} !== 3'b000) begin errors++; $display("FAIL hit_pulses c%0d got %b exp 000", c, {axi_read_start, axi_write_start, block_we}); end
            checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL hit_state c%0d got %0d exp 0", c, dbg_state); end
        end
        mem_access = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_access = 1'b1; dcache_hit = (c >= 10); dcache_dirty = 1'b0;
            addr = (c < 5) ? 64'h5000_0080 : 64'h6000_00C7;
            axi_done = (c == 3 || c == 8); axi_rdata = (c < 5) ? blk_a : blk_b;
            #1;
            checks++; if (stall !== (c < 10)) begin errors++; $display("FAIL b2b_stall c%0d got %b exp %b", c, stall, c < 10); end
            checks++; if (axi_read_start !== (c == 1 || c == 6)) begin errors++; $display("FAIL b2b_rd_start c%0d got %b exp %b", c, axi_read_start, c == 1 || c == 6); end
            checks++; if (block_we !== (c == 4 || c == 9)) begin errors++; $display("FAIL b2b_we c%0d got %b exp %b", c, block_we, c == 4 || c == 9); end
            if (c == 1) begin
                checks++; if (axi_addr !== 64'h5000_0080) begin errors++; $display("FAIL b2b_addr1 got %h exp 50000080", axi_addr); end
            end
            if (c == 4) begin
                checks++; if (data_block !== blk_a) begin errors++; $display("FAIL b2b_data1 got %h exp %h", data_block, blk_a); end
            end
            if (c == 5) begin
                checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL b2b_idle_gap got %0d exp 0", dbg_state); end
            end
            if (c == 6) begin
                checks++; if (axi_addr !== 64'h6000_00C0) begin errors++; $display("FAIL b2b_addr2 got %h exp 600000c0", axi_addr); end
            end
            if (c == 9) begin
                checks++; if (data_block !== blk_b) begin errors++; $display("FAIL b2b_data2 got %h exp %h", data_block, blk_b); end
            end
        end
        axi_done = 1'b0; mem_access = 1'b0;
        checks++; if (miss_cnt !== 32'd2 || wb_cnt !== 32'd0) begin errors++; $display("FAIL b2b_cnt got %0d/%0d exp 2/0", miss_cnt, wb_cnt); end
    endtask

    initial begin
        arst = 1'b1; mem_access = 1'b0; dcache_hit = 1'b0; dcache_dirty = 1'b0;
        addr = '0; addr_wb = '0; victim_block = '0; axi_done = 1'b0; axi_rdata = '0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_spurious_done();
        test_reset_mid_rd();
        test_hit_no_access();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Miss/refill sequencer for the data cache in the memory stage. Detects a dcache miss on a memory access and stalls the pipeline. Runs a dirty-victim writeback, then a block fetch over the AXI block interface, then writes the fetched block into the cache. It is the only issuer of block-level AXI requests on the data side and the only driver of the cache's block write enable.

## Interface
- ADDR_WIDTH, 64, byte address width
- BLOCK_WIDTH, 512, cache block width in bits; block offset bits OFS = log2(BLOCK_WIDTH/8) = 6
- CNT_WIDTH, 32, width of performance counters

- clk_i  in  1  clock; all state updates on rising edge
- arst_i  in  1  reset, synchronous, active-high
- mem_access_i  in  1  memory-stage instruction is a load or store
- dcache_hit_i  in  1  dcache hit for current address (combinational from cache)
- dcache_dirty_i  in  1  indexed victim line is dirty
- addr_i  in  ADDR_WIDTH  memory-stage access address
- addr_wb_i  in  ADDR_WIDTH  victim writeback address from cache
- victim_block_i  in  BLOCK_WIDTH  victim block from cache
- axi_done_i  in  1  single-cycle pulse: outstanding AXI transaction complete
- axi_rdata_i  in  BLOCK_WIDTH  fetched block, valid when axi_done_i during read
- stall_o  out  1  freeze fetch..memory stages
- axi_read_start_o  out  1  single-cycle pulse: start block read
- axi_write_start_o  out  1  single-cycle pulse: start block write
- axi_addr_o  out  ADDR_WIDTH  block-aligned address of current request
- axi_wdata_o  out  BLOCK_WIDTH  block to write back
- block_we_o  out  1  write data_block_o into cache line for addr_i
- data_block_o  out  BLOCK_WIDTH  refill block
- miss_cnt_o  out  CNT_WIDTH  completed refills
- wb_cnt_o  out  CNT_WIDTH  completed writebacks

## Operation
- States: IDLE, WB, RD, FILL.
- miss = mem_access_i & ~dcache_hit_i, evaluated only in IDLE.
- IDLE, miss & dcache_dirty_i: latch addr_wb_i (low OFS bits cleared) into axi_addr_o and victim_block_i into axi_wdata_o. Latch addr_i into a refill-address register. Go to WB.
- IDLE, miss & ~dcache_dirty_i: axi_addr_o <= addr_i with low OFS bits cleared. Go to RD.
- WB: axi_write_start_o = 1 in the first WB cycle only. On axi_done_i: wb_cnt_o += 1, axi_addr_o <= latched refill address, go to RD.
- RD: axi_read_start_o = 1 in the first RD cycle only. On axi_done_i: capture axi_rdata_i into data_block_o, go to FILL.
- FILL: block_we_o = 1 for exactly one cycle. miss_cnt_o += 1. Go to IDLE.
- stall_o = (state != IDLE) | miss. It is combinational, so the missing instruction stalls in its detection cycle.
- Counters wrap modulo 2^CNT_WIDTH.
- axi_done_i in IDLE or FILL is ignored.
- axi_done_i in the same cycle as a start pulse is ignored; done is honored only from the cycle after the start pulse.
- mem_access_i, addr_i and dcache_dirty_i are ignored outside IDLE. The pipeline is frozen, so they are stable anyway.
- Only one transaction is outstanding at a time.
- Reset (any state, including mid-transaction):
  - state -> IDLE.
  - All outputs 0: stall_o, both start pulses, block_we_o, axi_addr_o, axi_wdata_o, data_block_o, miss_cnt_o, wb_cnt_o.
  - A transaction in flight is abandoned. The AXI master shares the same reset.

## Timing
- Cycle 0 = first cycle miss is seen in IDLE. stall_o = 1 in cycle 0.
- Clean miss:
  - cycle 1: RD, axi_read_start_o = 1.
  - done at cycle k ≥ 2: FILL at k+1 with block_we_o = 1.
  - IDLE at k+2, where the cache hits and stall_o drops (if hit).
- Dirty miss:
  - cycle 1: WB, axi_write_start_o = 1.
  - write done at cycle j: RD at j+1 with axi_read_start_o = 1.
  - read done at k: FILL at k+1, IDLE at k+2.
- Start pulses, block_we_o, axi_addr_o, axi_wdata_o and data_block_o are registered outputs, not combinational.
- Back-to-back misses: a new miss may be accepted in the IDLE cycle immediately after FILL.

## Test plan
- Reset: hold arst_i 2 cycles in any state -> all outputs 0, state IDLE, counters 0.
- Clean miss: addr_i = 0x8000_1234, dirty = 0, done 5 cycles after the start pulse:
  - axi_read_start_o pulses once with axi_addr_o = 0x8000_1200.
  - block_we_o pulses once with data_block_o = axi_rdata_i.
  - stall_o high for 8 cycles, miss_cnt_o = 1, wb_cnt_o = 0.
- Dirty miss: addr_i = 0x1040, addr_wb_i = 0x2040, dirty = 1:
  - write pulse with axi_addr_o = 0x2040 and axi_wdata_o = victim.
  - then read pulse with axi_addr_o = 0x1040.
  - final counts: wb_cnt_o = 1, miss_cnt_o = 1.
- Spurious done: axi_done_i pulsed in IDLE, and again coincident with the start pulse -> no state change, no counter change.
- Reset mid-RD (2 cycles after read start) -> IDLE next cycle. Any later done is ignored, no block_we_o.
- Hit / no-access: mem_access_i = 1 with hit = 1, then mem_access_i = 0 with hit = 0 -> stall_o = 0, no AXI pulses.
